// File: rtl/irq_arbiter.sv
// Fixed-priority external interrupt arbiter with claim/complete tracking for the CSR meip input.
// Optional edge-triggered sources are built when IRQ_ARBITER_EDGE_EN is defined.
module irq_arbiter #(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             ack_i,
  output logic             meip_o,
  input  logic             sel_i,
  input  logic             wen_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             busy_o
);

  localparam int unsigned IDW = 5;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, next_state;
  logic [N_SRC-1:0] sync1, sync2, pending, enable, in_service;
  logic [N_SRC-1:0] eligible, edge_sel, edge_rise, pend_nxt, take_mask, done_mask, w1c_mask;
  logic [IDW-1:0]   claimed, last_id, win_id, take_id;
  logic             any_elig, take, complete, claim_wr;

  assign eligible  = pending & enable & ~in_service;
  assign any_elig  = |eligible;
  assign claim_wr  = sel_i & wen_i & (addr_i == 2'd2);
  assign take_id   = any_elig ? win_id : last_id;
  assign take_mask = take ? (N_SRC'(1) << take_id) : '0;
  assign done_mask = complete ? (N_SRC'(1) << claimed) : '0;

`ifdef IRQ_ARBITER_EDGE_EN
  logic [N_SRC-1:0] edge_reg, sync2_d;

  assign edge_sel  = edge_reg;
  assign edge_rise = sync2 & ~sync2_d;
  assign w1c_mask  = (sel_i & wen_i & (addr_i == 2'd0)) ? (wdata_i[N_SRC-1:0] & edge_reg) : '0;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      edge_reg <= '0;
      sync2_d  <= '0;
    end else begin
      sync2_d <= sync2;
      if (sel_i && wen_i && addr_i == 2'd3) edge_reg <= wdata_i[N_SRC-1:0];
    end
  end
`else
  assign edge_sel  = '0;
  assign edge_rise = '0;
  assign w1c_mask  = '0;
`endif

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = IDW'(i);
    end
  end

  // Level bits follow sync2 but freeze while in service (released on the completing edge).
  always_comb begin
    logic [N_SRC-1:0] hold;
    logic [N_SRC-1:0] lvl;
    logic [N_SRC-1:0] edg;
    hold     = in_service & ~done_mask;
    lvl      = (sync2 & ~hold) | (pending & hold);
    edg      = (pending | edge_rise) & ~take_mask & ~w1c_mask;
    pend_nxt = (lvl & ~edge_sel) | (edg & edge_sel);
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE:    if (any_elig) next_state = REQ;
      REQ: begin
        if (ack_i) begin
          take       = 1'b1;
          next_state = SERVICE;
        end else if (!any_elig) begin
          next_state = IDLE;
        end
      end
      SERVICE: begin
        if (claim_wr) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
      pending    <= '0;
      enable     <= '0;
      in_service <= '0;
      claimed    <= '0;
      last_id    <= '0;
      meip_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= next_state;
      sync1      <= irq_i;
      sync2      <= sync1;
      pending    <= pend_nxt;
      in_service <= (in_service | take_mask) & ~done_mask;
      meip_o     <= (next_state == REQ);
      busy_o     <= (next_state == SERVICE);
      if (any_elig) last_id <= win_id;
      if (take) claimed <= take_id;
      if (sel_i && wen_i && addr_i == 2'd1) enable <= wdata_i[N_SRC-1:0];
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rdata_o <= '0;
    end else if (sel_i && !wen_i) begin
      case (addr_i)
        2'd0:    rdata_o <= 32'(pending);
        2'd1:    rdata_o <= 32'(enable);
        2'd2:    rdata_o <= (state == SERVICE) ? (32'(claimed) + 32'd1) : 32'd0;
        default: rdata_o <= 32'(edge_sel);
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboarded bench for irq_arbiter: directed scenarios plus randomized level-source claim rounds.
module tb_irq_arbiter;

  localparam int unsigned N_SRC = 8;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b0;
  logic [N_SRC-1:0] irq_i = '0;
  logic             ack_i = 1'b0;
  logic             meip_o;
  logic             sel_i = 1'b0;
  logic             wen_i = 1'b0;
  logic [1:0]       addr_i = '0;
  logic [31:0]      wdata_i = '0;
  logic [31:0]      rdata_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_due = 1'b0;

  irq_arbiter #(.N_SRC(N_SRC)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .irq_i(irq_i), .ack_i(ack_i), .meip_o(meip_o),
    .sel_i(sel_i), .wen_i(wen_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read response is on rdata_o.
  always @(negedge clk_i) begin
    if (rd_due) begin
      rd_due = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: read response with empty queue, got 0x%0h", rdata_o);
      end else begin
        check(name_q.pop_front(), rdata_o, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel_i = 1'b1; wen_i = 1'b1; addr_i = a; wdata_i = d;
    step();
    sel_i = 1'b0; wen_i = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    sel_i = 1'b1; wen_i = 1'b0; addr_i = a;
    step();
    sel_i = 1'b0;
    rd_due = 1'b1;
    step();
  endtask

  task automatic pulse_ack();
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
  endtask

  task automatic wait_meip(input string nm);
    int n = 0;
    while (meip_o !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    check(nm, 32'(meip_o), 32'd1);
  endtask

  // Reference: the claim id is one plus the lowest index of the enabled active lines.
  function automatic logic [31:0] model_claim(input logic [N_SRC-1:0] lines, input logic [N_SRC-1:0] en);
    logic [N_SRC-1:0] act;
    act = lines & en;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (act[i]) return 32'(i + 1);
    end
    return 32'd0;
  endfunction

  initial begin
    logic [N_SRC-1:0] en, lines;
    logic [31:0] exp_id;

    step(2);
    check("reset_meip", 32'(meip_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    reset_i = 1'b1;
    step(2);

    // Bits above N_SRC are write-ignored.
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, 32'h0000_00FF, "enable_width");

    // Test 1: latency and basic claim/complete.
    bus_write(2'd1, 32'h01);
    irq_i[0] = 1'b1;
    step(3);
    check("t1_meip_k2", 32'(meip_o), 32'd0);
    step();
    check("t1_meip_k3", 32'(meip_o), 32'd1);
    pulse_ack();
    check("t1_meip_after_ack", 32'(meip_o), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd1);
    bus_read(2'd2, 32'd1, "t1_claim");
    irq_i[0] = 1'b0;
    step(3);
    bus_write(2'd2, 32'h0);
    check("t1_busy_done", 32'(busy_o), 32'd0);
    step(3);
    check("t1_idle", 32'(meip_o), 32'd0);

    // Test 2: priority, then re-request after completion.
    bus_write(2'd1, 32'hFF);
    irq_i[5] = 1'b1; irq_i[2] = 1'b1;
    wait_meip("t2_meip");
    pulse_ack();
    bus_read(2'd2, 32'd3, "t2_claim_a");
    irq_i[2] = 1'b0;
    step(3);
    bus_write(2'd2, 32'h0);
    check("t2_meip_idle", 32'(meip_o), 32'd0);
    step();
    check("t2_meip_rereq", 32'(meip_o), 32'd1);
    pulse_ack();
    bus_read(2'd2, 32'd6, "t2_claim_b");
    irq_i[5] = 1'b0;
    step(3);
    bus_write(2'd2, 32'h0);
    step(3);

    // Test 3: disable while requesting, then stray ack in IDLE.
    bus_write(2'd1, 32'h08);
    irq_i[3] = 1'b1;
    wait_meip("t3_meip");
    bus_write(2'd1, 32'h00);
    step();
    check("t3_meip_drop", 32'(meip_o), 32'd0);
    pulse_ack();
    check("t3_busy_stray_ack", 32'(busy_o), 32'd0);
    check("t3_meip_stray_ack", 32'(meip_o), 32'd0);
    bus_read(2'd2, 32'd0, "t3_claim_idle");
    irq_i[3] = 1'b0;
    step(3);

`ifdef IRQ_ARBITER_EDGE_EN
    // Edge source capture and write-1-to-clear.
    bus_write(2'd3, 32'h02);
    bus_write(2'd1, 32'h02);
    irq_i[1] = 1'b1;
    step();
    irq_i[1] = 1'b0;
    wait_meip("edge_meip");
    bus_read(2'd0, 32'h02, "edge_pending");
    bus_write(2'd0, 32'h02);
    step();
    check("edge_meip_clear", 32'(meip_o), 32'd0);
    bus_read(2'd0, 32'h00, "edge_pending_clear");
    bus_write(2'd3, 32'h00);
`else
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, 32'h00, "edge_absent");
`endif

    // Test 5: no nesting; held request is presented after completion.
    bus_write(2'd1, 32'h11);
    irq_i[4] = 1'b1;
    wait_meip("t5_meip");
    pulse_ack();
    bus_read(2'd2, 32'd5, "t5_claim_a");
    irq_i[0] = 1'b1;
    irq_i[4] = 1'b0;
    step(5);
    check("t5_meip_held", 32'(meip_o), 32'd0);
    bus_write(2'd2, 32'h0);
    check("t5_meip_idle", 32'(meip_o), 32'd0);
    step();
    check("t5_meip_present", 32'(meip_o), 32'd1);
    pulse_ack();
    bus_read(2'd2, 32'd1, "t5_claim_b");
    irq_i[0] = 1'b0;
    step(3);
    bus_write(2'd2, 32'h0);
    step(3);

    // Randomized level-source claim rounds against the priority model.
    for (int it = 0; it < 24; it++) begin
      en = N_SRC'($urandom) | N_SRC'(1 << $urandom_range(0, N_SRC - 1));
      lines = N_SRC'($urandom);
      lines[$urandom_range(0, N_SRC - 1)] = 1'b1;
      if ((lines & en) == '0) lines = lines | en;
      exp_id = model_claim(lines, en);
      bus_write(2'd1, 32'(en));
      irq_i = lines;
      wait_meip($sformatf("rnd%0d_meip", it));
      step($urandom_range(0, 3));
      pulse_ack();
      check($sformatf("rnd%0d_busy", it), 32'(busy_o), 32'd1);
      bus_read(2'd2, exp_id, $sformatf("rnd%0d_claim", it));
      bus_read(2'd0, 32'(lines), $sformatf("rnd%0d_pending", it));
      irq_i = '0;
      step(4);
      bus_write(2'd2, 32'(N_SRC'($urandom)));
      step(4);
      check($sformatf("rnd%0d_idle_meip", it), 32'(meip_o), 32'd0);
      check($sformatf("rnd%0d_idle_busy", it), 32'(busy_o), 32'd0);
    end

    // Test 6: asynchronous reset during service.
    bus_write(2'd1, 32'h04);
    irq_i[2] = 1'b1;
    wait_meip("t6_meip");
    pulse_ack();
    bus_read(2'd2, 32'd3, "t6_claim");
    #2;
    reset_i = 1'b0;
    #1;
    check("t6_rst_meip", 32'(meip_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_rdata", rdata_o, 32'd0);
    irq_i = '0;
    step(2);
    reset_i = 1'b1;
    step(2);
    bus_read(2'd1, 32'd0, "t6_enable_after_rst");
    check("t6_busy_after_rst", 32'(busy_o), 32'd0);

    step(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d reads unanswered, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- External interrupt controller in front of the core's CSR unit. It collects N_SRC peripheral interrupt lines, masks them, and arbitrates by fixed priority.
- Drives the machine external interrupt request (meip_o → CSR meip input) and tracks claim/complete using the CSR unit's one-cycle ack pulse plus a memory-mapped claim/complete register read and written by the trap handler.

Parameters:
- N_SRC, 8, number of interrupt sources (1..31); source 0 has the highest priority.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- irq_i  input  N_SRC  raw interrupt lines, asynchronous to clk_i.
- ack_i  input  1  one-cycle pulse from the CSR unit when it takes the external interrupt trap.
- meip_o  output  1  external interrupt request to the CSR unit.
- sel_i  input  1  bus access strobe, one cycle per access.
- wen_i  input  1  1 = write, 0 = read; valid with sel_i.
- addr_i  input  2  word offset: 0 PENDING, 1 ENABLE, 2 CLAIM, 3 EDGE.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data, registered.
- busy_o  output  1  high while an interrupt is in service.

Behaviour:
- Reset (reset_i low, async): all registers cleared; meip_o=0, rdata_o=0, busy_o=0, state IDLE, claimed id=0, sync flops=0.
- Input sync: irq_i goes through 2 flops per bit. pending[i] updates from sync stage 2.
- Level source: pending[i] = sync2[i], recomputed every cycle except bits marked claimed.
- Edge source: pending[i] sets on a rising edge of sync2[i]. It clears on claim or on a write-1 to PENDING.
- Eligible = pending & ENABLE & ~in_service. Winner = lowest-index eligible bit.
- States:
  - IDLE: if any bit is eligible, go to REQ.
  - REQ: meip_o=1. On ack_i=1, latch winner id into claimed, set in_service[winner], clear edge-pending[winner], go to SERVICE. If eligible becomes empty (source dropped or disabled) before ack_i, return to IDLE.
  - SERVICE: meip_o=0, busy_o=1. Any write to CLAIM (data ignored) clears in_service[claimed] and returns to IDLE.
- meip_o is registered and changes on the clock edge that enters or leaves REQ.
- Latency: irq_i high at rising edge k → sync2 at k+1 → pending at k+2 → state REQ and meip_o=1 at k+3.
- ack_i in IDLE or SERVICE: ignored, no state change.
- ack_i arriving on the same cycle REQ would drop to IDLE: ack wins; the winner sampled that cycle is claimed.
- CLAIM read returns {27'b0, claimed+1} in SERVICE, 0 otherwise. Reads have no side effects.
- CLAIM write outside SERVICE: ignored.
- A new higher-priority interrupt during SERVICE is held pending (no nesting). It is presented in the cycle after IDLE is entered.
- Register reads: rdata_o valid one cycle after sel_i & ~wen_i. rdata_o holds its value otherwise. Bits ≥ N_SRC read 0 and are write-ignored.
- ENABLE and EDGE are read/write. PENDING is read-only, except write-1-to-clear on edge bits.
- Reset asserted mid-service: everything returns to reset values immediately. No completion is required afterwards.

Optional Feature:
- Macro IRQ_ARBITER_EDGE_EN.
- Defined: EDGE register implemented; edge capture as described.
- Undefined: all sources are level-triggered. EDGE reads 0, EDGE writes are ignored, PENDING write-1-clear has no effect, and no edge-detect flops are synthesized.

Test Plan:
- ENABLE=0x01; raise irq_i[0] at edge k → meip_o=1 at k+3. Pulse ack_i → meip_o=0, busy_o=1, CLAIM read=1. Write CLAIM → busy_o=0, IDLE.
- ENABLE=0xFF; raise irq_i[5] and irq_i[2] together; ack → CLAIM reads 3. Complete with irq_i[5] still high → meip_o=1 again 1 cycle after IDLE; next claim reads 6.
- ENABLE=0x08; raise irq_i[3]; clear ENABLE before ack_i → meip_o returns to 0, state IDLE. ack_i pulse in IDLE → no state change, CLAIM reads 0.
- (IRQ_ARBITER_EDGE_EN) EDGE=0x02, ENABLE=0x02; 1-cycle pulse on irq_i[1] → PENDING reads 0x2 and meip_o=1. Write PENDING=0x2 → PENDING reads 0, meip_o=0.
- In SERVICE on source 4, raise irq_i[0] → meip_o stays 0 until CLAIM is written, then rises; next claim reads 1.
- Assert reset_i low during SERVICE → meip_o=0, busy_o=0, rdata_o=0 asynchronously; ENABLE reads 0 after release.
